// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staggered per-domain reset release, then run-cycle counter and clock-enable.
// All outputs registered (one-edge latency, no backpressure); optional watchdog re-reset under `RST_SEQ_WDOG_EN`.
module rst_seq_gen #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 8,
  parameter int CNT_W       = 8,
  parameter int DIV         = 2,
  parameter int WDOG_LIMIT  = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Ext_Rst_Req,
  input  logic              Wdog_Kick,
  output logic [NUM_CH-1:0] Ch_Rst,
  output logic              All_Released,
  output logic [31:0]       Cycle_Cnt,
  output logic              Ce_Out,
  output logic              Wdog_Fired
);

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d, ch_shift;
  logic              rel_q, rel_d;
  logic [31:0]       cyc_cnt_q, cyc_cnt_d;
  logic              ce_q, ce_d;
  logic              wdog_trip;
  logic              restart;
  logic              step_done;

`ifdef RST_SEQ_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              fired_q, fired_d;

  assign wdog_trip = (state_q == S_RUN) && (wdog_cnt_q == WDOG_W'(WDOG_LIMIT - 1)) && !Wdog_Kick;

  always_comb begin
    wdog_cnt_d = '0;
    fired_d    = fired_q | (wdog_trip & ~Ext_Rst_Req);
    if (!restart && state_q == S_RUN) begin
      wdog_cnt_d = Wdog_Kick ? '0 : wdog_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wdog_cnt_q <= '0;
      fired_q    <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      fired_q    <= fired_d;
    end
  end

  assign Wdog_Fired = fired_q;
`else
  logic [31:0] unused_wdog;

  assign unused_wdog = {Wdog_Kick, 31'(WDOG_LIMIT)};
  assign wdog_trip   = 1'b0;
  assign Wdog_Fired  = 1'b0;
`endif

  assign restart  = Ext_Rst_Req | wdog_trip;
  // Channels release low-to-high, so each release step is a left shift of the reset vector.
  assign ch_shift = ch_rst_q << 1;
  assign step_done = ((state_q == S_HOLD)    && (cnt_q == CNT_W'(HOLD_CYCLES - 1))) ||
                     ((state_q == S_RELEASE) && (cnt_q == CNT_W'(STAGGER - 1)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_rst_d  = ch_rst_q;
    rel_d     = rel_q;
    cyc_cnt_d = cyc_cnt_q;
    if (restart) begin
      state_d   = S_HOLD;
      cnt_d     = '0;
      ch_rst_d  = '1;
      rel_d     = 1'b0;
      cyc_cnt_d = '0;
    end else begin
      case (state_q)
        S_HOLD, S_RELEASE: begin
          if (step_done) begin
            cnt_d    = '0;
            ch_rst_d = ch_shift;
            if (ch_shift == '0) begin
              state_d   = S_RUN;
              rel_d     = 1'b1;
              cyc_cnt_d = '0;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN:   cyc_cnt_d = cyc_cnt_q + 32'd1;
        default: state_d = S_HOLD;
      endcase
    end
    ce_d = (state_d == S_RUN) && ((cyc_cnt_d % 32'(DIV)) == 32'(DIV - 1));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      ch_rst_q  <= '1;
      rel_q     <= 1'b0;
      cyc_cnt_q <= '0;
      ce_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_rst_q  <= ch_rst_d;
      rel_q     <= rel_d;
      cyc_cnt_q <= cyc_cnt_d;
      ce_q      <= ce_d;
    end
  end

  assign Ch_Rst       = ch_rst_q;
  assign All_Released = rel_q;
  assign Cycle_Cnt    = cyc_cnt_q;
  assign Ce_Out       = ce_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: directed sequences plus random restarts/kicks against an edge-count reference model.
module tb_rst_seq_gen;

  localparam int NUM_CH     = 4;
  localparam int HOLD       = 16;
  localparam int STAGGER    = 8;
  localparam int DIV        = 2;
  localparam int WDOG_LIMIT = 32;
  localparam int T_RUN      = HOLD + (NUM_CH - 1) * STAGGER;
`ifdef RST_SEQ_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              Ext_Rst_Req = 1'b0;
  logic              Wdog_Kick = 1'b0;
  logic [NUM_CH-1:0] Ch_Rst;
  logic              All_Released;
  logic [31:0]       Cycle_Cnt;
  logic              Ce_Out;
  logic              Wdog_Fired;

  int nchk = 0;
  int nerr = 0;

  // Model: k = edges since the last restart edge; every output follows from k.
  longint            k = 0;
  bit                m_fired = 1'b0;
  int                m_wd = 0;
  logic [NUM_CH-1:0] exp_ch;
  logic              exp_rel;
  logic [31:0]       exp_cyc;
  logic              exp_ce;
  logic              exp_fired;

  rst_seq_gen #(
    .NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .STAGGER(STAGGER), .CNT_W(8), .DIV(DIV), .WDOG_LIMIT(WDOG_LIMIT)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Ext_Rst_Req(Ext_Rst_Req), .Wdog_Kick(Wdog_Kick),
    .Ch_Rst(Ch_Rst), .All_Released(All_Released), .Cycle_Cnt(Cycle_Cnt), .Ce_Out(Ce_Out),
    .Wdog_Fired(Wdog_Fired)
  );

  always #5 Clk = ~Clk;

  function void model_edge();
    if (Rst) begin
      k = 0; m_fired = 1'b0; m_wd = 0;
    end else if (Ext_Rst_Req) begin
      k = 0; m_wd = 0;
    end else if (WDOG_ON && k >= T_RUN && m_wd == WDOG_LIMIT - 1 && !Wdog_Kick) begin
      k = 0; m_wd = 0; m_fired = 1'b1;
    end else begin
      if (k >= T_RUN) m_wd = Wdog_Kick ? 0 : m_wd + 1;
      k++;
    end
    for (int i = 0; i < NUM_CH; i++) exp_ch[i] = (k < longint'(HOLD + i * STAGGER));
    exp_rel   = (k >= T_RUN);
    exp_cyc   = exp_rel ? 32'(k - T_RUN) : 32'd0;
    exp_ce    = exp_rel && ((exp_cyc % 32'(DIV)) == 32'(DIV - 1));
    exp_fired = m_fired;
  endfunction

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b1; Ext_Rst_Req = 1'b0; Wdog_Kick = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      nchk++;
      if ({Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired} !== {4'b1111, 1'b0, 32'd0, 1'b0, 1'b0}) begin
        nerr++;
        $display("FAIL reset: got ch=%b rel=%b cnt=%h ce=%b wf=%b, want ch=1111 rel=0 cnt=0 ce=0 wf=0",
                 Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired);
      end
    end
  endtask

  task automatic test_release_sequence();
    logic [3:0] want;
    Rst = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      nchk++;
      if ({Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired} !== {exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired}) begin
        nerr++;
        $display("FAIL release_model j=%0d: got ch=%b rel=%b cnt=%h ce=%b wf=%b, want ch=%b rel=%b cnt=%h ce=%b wf=%b",
                 j, Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired, exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired);
      end
      if (j inside {15, 16, 24, 32, 40}) begin
        want = (j == 15) ? 4'b1111 : (j == 16) ? 4'b1110 : (j == 24) ? 4'b1100 : (j == 32) ? 4'b1000 : 4'b0000;
        nchk++;
        if (Ch_Rst !== want || All_Released !== (j == 40) || (j == 40 && Cycle_Cnt !== 32'd0)) begin
          nerr++;
          $display("FAIL release_timing E+%0d: got ch=%b rel=%b cnt=%0d, want ch=%b rel=%b cnt=0",
                   j, Ch_Rst, All_Released, Cycle_Cnt, want, (j == 40));
        end
      end
    end
  endtask

  task automatic test_run_counter();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      nchk++;
      if (Cycle_Cnt !== 32'(i) || Ce_Out !== (i % 2 == 1) || All_Released !== 1'b1) begin
        nerr++;
        $display("FAIL run_counter i=%0d: got cnt=%0d ce=%b rel=%b, want cnt=%0d ce=%b rel=1",
                 i, Cycle_Cnt, Ce_Out, All_Released, i, (i % 2 == 1));
      end
    end
  endtask

  task automatic test_ext_restart();
    bit reached = 1'b0;
    Ext_Rst_Req = 1'b1;
    tick();
    Ext_Rst_Req = 1'b0;
    for (int n = 0; n < 100 && !reached; n++) begin
      tick();
      nchk++;
      if ({Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired} !== {exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired}) begin
        nerr++;
        $display("FAIL ext_resequence n=%0d: got ch=%b rel=%b cnt=%h ce=%b wf=%b, want ch=%b rel=%b cnt=%h ce=%b wf=%b",
                 n, Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired, exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired);
      end
      if (All_Released === 1'b1 && Cycle_Cnt === 32'd5) reached = 1'b1;
    end
    nchk++;
    if (!reached) begin
      nerr++;
      $display("FAIL ext_wait: Cycle_Cnt=5 not seen within 100 cycles, got cnt=%0d rel=%b", Cycle_Cnt, All_Released);
    end
    Ext_Rst_Req = 1'b1;
    tick();
    Ext_Rst_Req = 1'b0;
    nchk++;
    if (Ch_Rst !== 4'b1111 || All_Released !== 1'b0 || Cycle_Cnt !== 32'd0 || Ce_Out !== 1'b0) begin
      nerr++;
      $display("FAIL ext_pulse: got ch=%b rel=%b cnt=%0d ce=%b, want ch=1111 rel=0 cnt=0 ce=0",
               Ch_Rst, All_Released, Cycle_Cnt, Ce_Out);
    end
    for (int j = 1; j <= 20; j++) begin
      tick();
      nchk++;
      if (Ch_Rst[0] !== (j < 16) || Ch_Rst[3:1] !== 3'b111) begin
        nerr++;
        $display("FAIL ext_hold j=%0d: got ch=%b, want ch0=%b upper=111", j, Ch_Rst, (j < 16));
      end
    end
  endtask

  task automatic test_mid_release_rst();
    logic [3:0] want;
    bit reached = 1'b0;
    for (int n = 0; n < 50 && !reached; n++) begin
      tick();
      if (Ch_Rst === 4'b1100) reached = 1'b1;
    end
    nchk++;
    if (!reached || exp_ch !== 4'b1100) begin
      nerr++;
      $display("FAIL mid_wait: ch=1100 not reached, got ch=%b model=%b", Ch_Rst, exp_ch);
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    nchk++;
    if (Ch_Rst !== 4'b1111 || All_Released !== 1'b0) begin
      nerr++;
      $display("FAIL mid_abort: got ch=%b rel=%b, want ch=1111 rel=0", Ch_Rst, All_Released);
    end
    for (int j = 1; j <= 41; j++) begin
      tick();
      nchk++;
      if ({Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired} !== {exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired}) begin
        nerr++;
        $display("FAIL mid_model j=%0d: got ch=%b rel=%b cnt=%h ce=%b wf=%b, want ch=%b rel=%b cnt=%h ce=%b wf=%b",
                 j, Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired, exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired);
      end
      if (j inside {16, 24, 32, 40}) begin
        want = (j == 16) ? 4'b1110 : (j == 24) ? 4'b1100 : (j == 32) ? 4'b1000 : 4'b0000;
        nchk++;
        if (Ch_Rst !== want) begin
          nerr++;
          $display("FAIL mid_timing E+%0d: got ch=%b, want ch=%b", j, Ch_Rst, want);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want_cnt;
    Wdog_Kick = 1'b1;
    force dut.cyc_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.cyc_cnt_q;
    k = T_RUN + 64'h0000_0000_FFFF_FFFD;
    for (int j = 1; j <= 4; j++) begin
      tick();
      want_cnt = 32'hFFFF_FFFD + 32'(j);
      nchk++;
      if (Cycle_Cnt !== want_cnt || All_Released !== 1'b1 || Ce_Out !== want_cnt[0] ||
          {Ch_Rst, Cycle_Cnt, Ce_Out} !== {exp_ch, exp_cyc, exp_ce}) begin
        nerr++;
        $display("FAIL wrap j=%0d: got cnt=%h rel=%b ce=%b ch=%b, want cnt=%h rel=1 ce=%b ch=0000",
                 j, Cycle_Cnt, All_Released, Ce_Out, Ch_Rst, want_cnt, want_cnt[0]);
      end
    end
    Wdog_Kick = 1'b0;
  endtask

  task automatic test_watchdog();
`ifdef RST_SEQ_WDOG_EN
    bit reached = 1'b0;
    int n_run = 0;
    Wdog_Kick = 1'b0;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int n = 0; n < 60 && !reached; n++) begin
      tick();
      if (All_Released === 1'b1) reached = 1'b1;
    end
    for (int n = 1; n <= 40 && n_run == 0; n++) begin
      tick();
      if (All_Released !== 1'b1) n_run = n;
    end
    nchk++;
    if (!reached || n_run != 32 || Wdog_Fired !== 1'b1 || Ch_Rst !== 4'b1111) begin
      nerr++;
      $display("FAIL wdog_timeout: got restart after %0d run edges wf=%b ch=%b, want 32 wf=1 ch=1111",
               n_run, Wdog_Fired, Ch_Rst);
    end
    for (int n = 0; n < 45; n++) begin
      tick();
      nchk++;
      if ({Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired} !== {exp_ch, exp_rel, exp_cyc, exp_ce, 1'b1}) begin
        nerr++;
        $display("FAIL wdog_sticky n=%0d: got ch=%b rel=%b cnt=%h ce=%b wf=%b, want ch=%b rel=%b cnt=%h ce=%b wf=1",
                 n, Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired, exp_ch, exp_rel, exp_cyc, exp_ce);
      end
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      Wdog_Kick = (n % 20 == 0);
      tick();
      nchk++;
      if ({Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired} !== {exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired}) begin
        nerr++;
        $display("FAIL wdog_kicked n=%0d: got ch=%b rel=%b cnt=%h ce=%b wf=%b, want ch=%b rel=%b cnt=%h ce=%b wf=%b",
                 n, Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired, exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired);
      end
    end
    Wdog_Kick = 1'b0;
    nchk++;
    if (Wdog_Fired !== 1'b0 || All_Released !== 1'b1 || Cycle_Cnt !== 32'd160) begin
      nerr++;
      $display("FAIL wdog_kicked_end: got wf=%b rel=%b cnt=%0d, want wf=0 rel=1 cnt=160",
               Wdog_Fired, All_Released, Cycle_Cnt);
    end
`else
    Wdog_Kick = 1'b0;
    for (int n = 0; n < 2 * WDOG_LIMIT; n++) begin
      tick();
      nchk++;
      if ({Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired} !== {exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired}) begin
        nerr++;
        $display("FAIL no_wdog n=%0d: got ch=%b rel=%b cnt=%h ce=%b wf=%b, want ch=%b rel=%b cnt=%h ce=%b wf=%b",
                 n, Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired, exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired);
      end
    end
    nchk++;
    if (Wdog_Fired !== 1'b0 || All_Released !== 1'b1) begin
      nerr++;
      $display("FAIL no_wdog_end: got wf=%b rel=%b, want wf=0 rel=1", Wdog_Fired, All_Released);
    end
`endif
  endtask

  task automatic test_random();
    int ext_left = 0;
    for (int n = 0; n < 1500; n++) begin
      Rst = ($urandom_range(0, 199) == 0);
      if (ext_left == 0 && $urandom_range(0, 149) == 0) ext_left = $urandom_range(1, 4);
      Ext_Rst_Req = (ext_left > 0);
      if (ext_left > 0) ext_left--;
      Wdog_Kick = ($urandom_range(0, 24) == 0);
      tick();
      nchk++;
      if ({Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired} !== {exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired}) begin
        nerr++;
        $display("FAIL random n=%0d k=%0d: got ch=%b rel=%b cnt=%h ce=%b wf=%b, want ch=%b rel=%b cnt=%h ce=%b wf=%b",
                 n, k, Ch_Rst, All_Released, Cycle_Cnt, Ce_Out, Wdog_Fired, exp_ch, exp_rel, exp_cyc, exp_ce, exp_fired);
      end
    end
    Rst = 1'b0; Ext_Rst_Req = 1'b0; Wdog_Kick = 1'b0;
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_release_sequence();
    test_run_counter();
    test_ext_restart();
    test_mid_release_rst();
    test_wrap();
    test_watchdog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
